// File: rtl/multicycle_control.sv
// Main control FSM for the shared multicycle MIPS datapath.
// Moore outputs from State; PCEn also uses Zero, Illegal also uses Op.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

    always_comb begin
        state_d  = S_FETCH;
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        Illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCEn    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (Op == OP_LW || Op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (Op == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (Op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (Op == OP_J) begin
                    state_d = S_JUMP;
                end else if (Op == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else begin
                    Illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCEn     = Zero;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCEn     = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset abandons the instruction: no enable or select may leak out.
        if (reset) begin
            PCEn     = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            MemToReg = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            PCSource = 2'b00;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_control;

    logic       clock;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic       RegDst, MemToReg, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q[$];
    string       name_q[$];
    logic [19:0] act;

    multicycle_control dut (
        .clock    (clock),
        .reset    (reset),
        .Op       (Op),
        .Zero     (Zero),
        .PCEn     (PCEn),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSource (PCSource),
        .Illegal  (Illegal),
        .State    (State)
    );

    // Rising edges at 4, 12, 20 ... so t=130 falls between edges.
    initial begin
        clock = 1'b0;
        #4;
        forever begin
            clock = 1'b1;
            #4;
            clock = 1'b0;
            #4;
        end
    end

    assign act = {State, PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  Illegal};

    // Hand-written expected outputs per state; s<0 means held in reset.
    function automatic logic [19:0] ev(input int s, input bit z,
                                       input bit ill);
        logic [3:0] st;
        logic pcen, iord, mr, mw, irw, rw, rd, m2r, sa, il;
        logic [1:0] sb, aop, pcs;
        st = 4'd0; pcen = 0; iord = 0; mr = 0; mw = 0; irw = 0; rw = 0;
        rd = 0; m2r = 0; sa = 0; il = 0; sb = 2'b00; aop = 2'b00;
        pcs = 2'b00;
        if (s >= 0) st = 4'(s);
        case (s)
            0:  begin mr = 1; irw = 1; sb = 2'b01; pcen = 1; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; sb = 2'b00; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            9:  begin pcs = 2'b10; pcen = 1; end
            10: begin sa = 1; sb = 2'b10; aop = 2'b00; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {st, pcen, iord, mr, mw, irw, rw, rd, m2r, sa, sb, aop, pcs,
                il};
    endfunction

    // Called at active edge + 1: expectation for the current cycle.
    task automatic step(input string nm, input int s, input bit z = 0,
                        input bit ill = 0);
        exp_q.push_back(ev(s, z, ill));
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    task automatic direct(input string nm, input logic [19:0] e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h", nm, act, e);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s t=%0t: got %05h expected %05h",
                         nm, $time, act, e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        Op    = 6'h02;
        Zero  = 1'b1;
        @(posedge clock);
        #1;
        step("reset_hold", -1);
        reset = 1'b0;

        Op = 6'h02; Zero = 1'b1;
        step("j_fetch", 0);
        step("j_decode", 1);
        step("j_jump", 9);

        Op = 6'h08;
        step("addi_fetch", 0);
        step("addi_decode", 1);
        step("addi_ex", 10);
        step("addi_wb", 11);

        Op = 6'h2B;
        step("sw_fetch", 0);
        step("sw_decode", 1);
        step("sw_memadr", 2);
        step("sw_memwr", 5);

        Op = 6'h23;
        step("lwr_fetch", 0);
        step("lwr_decode", 1);
        step("lwr_memadr", 2);
        exp_q.push_back(ev(3, 0, 0));
        name_q.push_back("lwr_memrd");
        #5;
        reset = 1'b1;
        #1;
        direct("reset_async_130", ev(-1, 0, 0));
        @(posedge clock);
        #1;
        step("reset_no_regwrite", -1);
        reset = 1'b0;

        step("lw_fetch", 0);
        step("lw_decode", 1);
        step("lw_memadr", 2);
        step("lw_memrd", 3);
        step("lw_memwb", 4);

        Op = 6'h00;
        step("r_fetch", 0);
        step("r_decode", 1);
        step("r_exec", 6);
        step("r_wb", 7);

        Op = 6'h04; Zero = 1'b1;
        step("beq1_fetch", 0);
        step("beq1_decode", 1);
        step("beq1_branch", 8, 1'b1);

        Zero = 1'b0;
        step("beq0_fetch", 0);
        step("beq0_decode", 1);
        step("beq0_branch", 8, 1'b0);

        Op = 6'h3F; Zero = 1'b1;
        step("ill1_fetch", 0);
        step("ill1_decode", 1, 0, 1);
        step("ill2_fetch", 0);
        step("ill2_decode", 1, 0, 1);
        Op = 6'h02;
        step("after_ill_fetch", 0);

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: left %0d expected 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
